regfile_port_ctrl: RTL and testbench

Shares the single-write, dual-read register file between the core pipeline and the debug module. Core accesses have priority; a saturating starvation counter guarantees debug progress. The block tracks the register file's one-cycle registered read latency and routes each response to its owner. It forwards same-cycle write data so reads never return stale values. It sits between the decode/writeback stages, the debug module and the register file.

---
 rtl/regfile_pkg.sv | 8 +
 rtl/starve_counter.sv | 21 ++
 rtl/regfile_port_ctrl.sv | 121 ++++++++++++
 tb/tb_regfile_port_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file port controller.
package regfile_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam logic [REG_ADDR_W-1:0] X0_ADDR = '0;

  typedef enum logic [1:0] {OWN_NONE, OWN_CORE, OWN_DBG} owner_e;
endpackage

// File: rtl/starve_counter.sv
// Saturating counter of stalled debug cycles; at_limit forces one debug grant.
module starve_counter #(
  parameter int LIMIT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clear,
  output logic at_limit
);
  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt;

  assign at_limit = (cnt == W'(LIMIT));

  always_ff @(posedge clk) begin
    if (reset || clear)       cnt <= '0;
    else if (inc && !at_limit) cnt <= cnt + W'(1);
  end
endmodule

// File: rtl/regfile_port_ctrl.sv
// Arbitrates core/debug access to a 1W2R register file, tracks the registered
// read latency, forwards same-cycle writes and routes responses to the owner.
module regfile_port_ctrl
  import regfile_pkg::*;
#(
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  core_rd_valid,
  output logic                  core_rd_ready,
  input  logic [REG_ADDR_W-1:0] core_rs1,
  input  logic [REG_ADDR_W-1:0] core_rs2,
  output logic                  core_rd_resp_valid,
  output logic [XLEN-1:0]       core_rs1_data,
  output logic [XLEN-1:0]       core_rs2_data,
  input  logic                  core_wr_valid,
  output logic                  core_wr_ready,
  input  logic [REG_ADDR_W-1:0] core_wr_addr,
  input  logic [XLEN-1:0]       core_wr_data,
  input  logic                  dbg_req_valid,
  output logic                  dbg_req_ready,
  input  logic                  dbg_req_write,
  input  logic [REG_ADDR_W-1:0] dbg_req_addr,
  input  logic [XLEN-1:0]       dbg_req_wdata,
  output logic                  dbg_resp_valid,
  output logic [XLEN-1:0]       dbg_resp_rdata,
  output logic                  rf_write_enable,
  output logic [REG_ADDR_W-1:0] rf_write_address,
  output logic [XLEN-1:0]       rf_write_data,
  output logic [REG_ADDR_W-1:0] rf_read_a_address,
  output logic [REG_ADDR_W-1:0] rf_read_b_address,
  input  logic [XLEN-1:0]       rf_read_a_data,
  input  logic [XLEN-1:0]       rf_read_b_data
);
  logic at_limit;
  logic dbg_rd, dbg_wr, dbg_rd_ready, dbg_wr_ready;
  logic core_rd_grant, core_wr_grant, dbg_rd_grant, dbg_wr_grant;

  assign dbg_rd = dbg_req_valid & ~dbg_req_write;
  assign dbg_wr = dbg_req_valid &  dbg_req_write;

  // Core wins each resource unless debug has starved long enough on it.
  assign core_rd_ready = ~reset & ~(dbg_rd & at_limit);
  assign core_wr_ready = ~reset & ~(dbg_wr & at_limit);
  assign dbg_rd_ready  = ~reset & (~core_rd_valid | at_limit);
  assign dbg_wr_ready  = ~reset & (~core_wr_valid | at_limit);
  assign dbg_req_ready = dbg_req_write ? dbg_wr_ready : dbg_rd_ready;

  assign core_rd_grant = core_rd_valid & core_rd_ready;
  assign core_wr_grant = core_wr_valid & core_wr_ready;
  assign dbg_rd_grant  = dbg_rd & dbg_rd_ready;
  assign dbg_wr_grant  = dbg_wr & dbg_wr_ready;

  starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk      (clk),
    .reset    (reset),
    .inc      (dbg_req_valid & ~dbg_req_ready),
    .clear    (dbg_rd_grant | dbg_wr_grant),
    .at_limit (at_limit)
  );

  always_comb begin
    rf_write_enable   = 1'b0;
    rf_write_address  = X0_ADDR;
    rf_write_data     = '0;
    rf_read_a_address = X0_ADDR;
    rf_read_b_address = X0_ADDR;
    if (core_wr_grant) begin
      rf_write_enable  = 1'b1;
      rf_write_address = core_wr_addr;
      rf_write_data    = core_wr_data;
    end else if (dbg_wr_grant) begin
      rf_write_enable  = 1'b1;
      rf_write_address = dbg_req_addr;
      rf_write_data    = dbg_req_wdata;
    end
    if (core_rd_grant) begin
      rf_read_a_address = core_rs1;
      rf_read_b_address = core_rs2;
    end else if (dbg_rd_grant) begin
      rf_read_a_address = dbg_req_addr;
    end
  end

  owner_e          owner_q;
  logic            dbg_wr_ack_q, fwd_a_q, fwd_b_q, zero_a_q, zero_b_q;
  logic [XLEN-1:0] wdata_q, data_a, data_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q      <= OWN_NONE;
      dbg_wr_ack_q <= 1'b0;
      fwd_a_q      <= 1'b0;
      fwd_b_q      <= 1'b0;
      zero_a_q     <= 1'b0;
      zero_b_q     <= 1'b0;
      wdata_q      <= '0;
    end else begin
      owner_q      <= core_rd_grant ? OWN_CORE : (dbg_rd_grant ? OWN_DBG : OWN_NONE);
      dbg_wr_ack_q <= dbg_wr_grant;
      fwd_a_q      <= rf_write_enable && rf_write_address == rf_read_a_address &&
                      rf_read_a_address != X0_ADDR;
      fwd_b_q      <= rf_write_enable && rf_write_address == rf_read_b_address &&
                      rf_read_b_address != X0_ADDR;
      zero_a_q     <= rf_read_a_address == X0_ADDR;
      zero_b_q     <= rf_read_b_address == X0_ADDR;
      wdata_q      <= rf_write_data;
    end
  end

  // x0 always reads 0; otherwise the same-cycle write wins over stale RF data.
  assign data_a = zero_a_q ? '0 : (fwd_a_q ? wdata_q : rf_read_a_data);
  assign data_b = zero_b_q ? '0 : (fwd_b_q ? wdata_q : rf_read_b_data);

  assign core_rd_resp_valid = ~reset & (owner_q == OWN_CORE);
  assign core_rs1_data      = core_rd_resp_valid ? data_a : '0;
  assign core_rs2_data      = core_rd_resp_valid ? data_b : '0;
  assign dbg_resp_valid     = ~reset & ((owner_q == OWN_DBG) | dbg_wr_ack_q);
  assign dbg_resp_rdata     = (~reset & (owner_q == OWN_DBG)) ? data_a : '0;
endmodule

// File: tb/tb_regfile_port_ctrl.sv
// Bench for regfile_port_ctrl: directed table, starvation/reset sequences and
// randomized traffic checked against an architectural register-state model.
module tb_regfile_port_ctrl;
  localparam int LIMIT = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        core_rd_valid, core_rd_ready, core_rd_resp_valid;
  logic [4:0]  core_rs1, core_rs2;
  logic [31:0] core_rs1_data, core_rs2_data;
  logic        core_wr_valid, core_wr_ready;
  logic [4:0]  core_wr_addr;
  logic [31:0] core_wr_data;
  logic        dbg_req_valid, dbg_req_ready, dbg_req_write, dbg_resp_valid;
  logic [4:0]  dbg_req_addr;
  logic [31:0] dbg_req_wdata, dbg_resp_rdata;
  logic        rf_write_enable;
  logic [4:0]  rf_write_address, rf_read_a_address, rf_read_b_address;
  logic [31:0] rf_write_data, rf_read_a_data, rf_read_b_data;

  regfile_port_ctrl #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .core_rd_valid(core_rd_valid), .core_rd_ready(core_rd_ready),
    .core_rs1(core_rs1), .core_rs2(core_rs2),
    .core_rd_resp_valid(core_rd_resp_valid),
    .core_rs1_data(core_rs1_data), .core_rs2_data(core_rs2_data),
    .core_wr_valid(core_wr_valid), .core_wr_ready(core_wr_ready),
    .core_wr_addr(core_wr_addr), .core_wr_data(core_wr_data),
    .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready),
    .dbg_req_write(dbg_req_write), .dbg_req_addr(dbg_req_addr),
    .dbg_req_wdata(dbg_req_wdata),
    .dbg_resp_valid(dbg_resp_valid), .dbg_resp_rdata(dbg_resp_rdata),
    .rf_write_enable(rf_write_enable), .rf_write_address(rf_write_address),
    .rf_write_data(rf_write_data),
    .rf_read_a_address(rf_read_a_address), .rf_read_b_address(rf_read_b_address),
    .rf_read_a_data(rf_read_a_data), .rf_read_b_data(rf_read_b_data)
  );

  // Register file device: registered reads see pre-write contents.
  logic [31:0] mem [32] = '{default: '0};
  logic [31:0] ra_q = '0, rb_q = '0;
  always @(posedge clk) begin
    if (rf_write_enable && rf_write_address != 5'd0) mem[rf_write_address] <= rf_write_data;
    ra_q <= mem[rf_read_a_address];
    rb_q <= mem[rf_read_b_address];
  end
  assign rf_read_a_data = ra_q;
  assign rf_read_b_data = rb_q;

  // Reference model: architectural register state, reads see same-cycle writes.
  logic [31:0] gold [32] = '{default: '0};
  int          starve = 0;
  logic        e_cv = 0, e_dv = 0;
  logic [31:0] e_c1 = 0, e_c2 = 0, e_dd = 0;

  int n_vec = 0, n_err = 0;
  logic        s_rrdy, s_drdy, s_cv, s_dv;
  logic [31:0] s_c1, s_c2, s_dd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle();
    core_rd_valid = 0; core_rs1 = 0; core_rs2 = 0;
    core_wr_valid = 0; core_wr_addr = 0; core_wr_data = 0;
    dbg_req_valid = 0; dbg_req_write = 0; dbg_req_addr = 0; dbg_req_wdata = 0;
  endtask

  // One clock: inputs are already driven; check, clock, advance the model.
  task automatic cycle();
    logic dr, dw, lim, e_crr, e_cwr, e_dr, cg_r, cg_w, dg, wen;
    logic [4:0] ra, rb;
    #1;
    dr  = dbg_req_valid & ~dbg_req_write;
    dw  = dbg_req_valid &  dbg_req_write;
    lim = (starve >= LIMIT);
    e_crr = ~reset & ~(dr & lim);
    e_cwr = ~reset & ~(dw & lim);
    e_dr  = ~reset & (dbg_req_write ? (~core_wr_valid | lim) : (~core_rd_valid | lim));
    chk("core_rd_ready", core_rd_ready, e_crr);
    chk("core_wr_ready", core_wr_ready, e_cwr);
    if (dbg_req_valid) chk("dbg_req_ready", dbg_req_ready, e_dr);
    chk("core_resp_valid", core_rd_resp_valid, e_cv & ~reset);
    chk("dbg_resp_valid", dbg_resp_valid, e_dv & ~reset);
    if (reset) begin
      chk("rs1_data_rst", core_rs1_data, 0);
      chk("dbg_rdata_rst", dbg_resp_rdata, 0);
    end else begin
      if (e_cv) begin
        chk("core_rs1_data", core_rs1_data, e_c1);
        chk("core_rs2_data", core_rs2_data, e_c2);
      end
      if (e_dv) chk("dbg_resp_rdata", dbg_resp_rdata, e_dd);
    end
    cg_r = core_rd_valid & e_crr;
    cg_w = core_wr_valid & e_cwr;
    dg   = dbg_req_valid & e_dr;
    wen  = cg_w | (dg & dw);
    chk("rf_write_enable", rf_write_enable, wen);
    chk("rf_write_address", rf_write_address,
        cg_w ? core_wr_addr : ((dg & dw) ? dbg_req_addr : 5'd0));
    if (wen) chk("rf_write_data", rf_write_data, cg_w ? core_wr_data : dbg_req_wdata);
    ra = cg_r ? core_rs1 : ((dg & dr) ? dbg_req_addr : 5'd0);
    rb = cg_r ? core_rs2 : 5'd0;
    chk("rf_read_a_address", rf_read_a_address, ra);
    chk("rf_read_b_address", rf_read_b_address, rb);
    s_rrdy = core_rd_ready; s_drdy = dbg_req_ready;
    s_cv = core_rd_resp_valid; s_c1 = core_rs1_data; s_c2 = core_rs2_data;
    s_dv = dbg_resp_valid; s_dd = dbg_resp_rdata;
    @(posedge clk);
    if (reset) begin
      e_cv = 0; e_dv = 0; starve = 0;
    end else begin
      if (cg_w && core_wr_addr != 0) gold[core_wr_addr] = core_wr_data;
      if (dg && dw && dbg_req_addr != 0) gold[dbg_req_addr] = dbg_req_wdata;
      e_cv = cg_r; e_c1 = gold[core_rs1]; e_c2 = gold[core_rs2];
      e_dv = dg;   e_dd = dw ? 32'd0 : gold[dbg_req_addr];
      if (dg) starve = 0;
      else if (dbg_req_valid && starve < LIMIT) starve++;
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic rv; logic [4:0] r1, r2;
    logic wv; logic [4:0] wa; logic [31:0] wd;
    logic dv, dw; logic [4:0] da; logic [31:0] dd;
    logic e_rrdy, e_resp; logic [31:0] e1, e2;
    logic e_dresp; logic [31:0] e_drd;
  } vec_t;
  vec_t vt [7];

  initial begin
    vt[0] = '{1, 3, 4, 0, 0, 0,          0, 0, 0, 0,          1, 1, 32'h11,   32'h22, 0, 0};
    vt[1] = '{1, 5, 0, 1, 5, 32'hA5A5,   0, 0, 0, 0,          1, 1, 32'hA5A5, 0,      0, 0};
    vt[2] = '{1, 5, 3, 0, 0, 0,          0, 0, 0, 0,          1, 1, 32'hA5A5, 32'h11, 0, 0};
    vt[3] = '{0, 0, 0, 0, 0, 0,          1, 1, 9, 32'hDEAD,   1, 0, 0,        0,      1, 0};
    vt[4] = '{1, 9, 0, 1, 0, 32'hFFFF,   0, 0, 0, 0,          1, 1, 32'hDEAD, 0,      0, 0};
    vt[5] = '{1, 0, 0, 1, 0, 32'hFFFF,   0, 0, 0, 0,          1, 1, 0,        0,      0, 0};
    vt[6] = '{0, 0, 0, 0, 0, 0,          0, 0, 0, 0,          1, 0, 0,        0,      0, 0};

    idle(); reset = 1;
    @(negedge clk);
    cycle(); cycle();
    reset = 0;
    cycle();

    // Preload through the core write port.
    for (int i = 1; i < 32; i++) begin
      core_wr_valid = 1; core_wr_addr = 5'(i);
      core_wr_data = (i == 3) ? 32'h11 : (i == 4) ? 32'h22 : (i == 7) ? 32'h77 : $urandom;
      cycle();
    end
    idle(); cycle();

    for (int i = 0; i < 7; i++) begin
      core_rd_valid = vt[i].rv; core_rs1 = vt[i].r1; core_rs2 = vt[i].r2;
      core_wr_valid = vt[i].wv; core_wr_addr = vt[i].wa; core_wr_data = vt[i].wd;
      dbg_req_valid = vt[i].dv; dbg_req_write = vt[i].dw;
      dbg_req_addr = vt[i].da; dbg_req_wdata = vt[i].dd;
      cycle();
      chk($sformatf("vec%0d_rd_ready", i), s_rrdy, vt[i].e_rrdy);
      idle(); cycle();
      chk($sformatf("vec%0d_resp", i), s_cv, vt[i].e_resp);
      if (vt[i].e_resp) begin
        chk($sformatf("vec%0d_rs1", i), s_c1, vt[i].e1);
        chk($sformatf("vec%0d_rs2", i), s_c2, vt[i].e2);
      end
      chk($sformatf("vec%0d_dresp", i), s_dv, vt[i].e_dresp);
      if (vt[i].e_dresp) chk($sformatf("vec%0d_drdata", i), s_dd, vt[i].e_drd);
    end

    // Starvation: debug read of x7 behind continuous core reads.
    core_rd_valid = 1; dbg_req_valid = 1; dbg_req_write = 0; dbg_req_addr = 7;
    for (int i = 0; i <= LIMIT; i++) begin
      core_rs1 = 5'($urandom_range(1, 31)); core_rs2 = 5'($urandom_range(1, 31));
      cycle();
      chk($sformatf("starve%0d_dbg_ready", i), s_drdy, (i == LIMIT));
      chk($sformatf("starve%0d_core_ready", i), s_rrdy, (i != LIMIT));
    end
    dbg_req_valid = 0; cycle();
    chk("starve_dbg_resp", s_dv, 1);
    chk("starve_dbg_rdata", s_dd, 32'h77);
    dbg_req_valid = 1; cycle();
    chk("starve_cleared", s_drdy, 0);
    idle(); cycle();

    // Reset while a core read is in flight.
    core_rd_valid = 1; core_rs1 = 3; core_rs2 = 4; cycle();
    idle(); reset = 1; cycle();
    chk("rst_flight_resp", s_cv, 0);
    reset = 0; cycle();
    chk("rst_release_resp", s_cv, 0);
    starve = 0;

    for (int n = 0; n < 500; n++) begin
      reset         = ($urandom_range(0, 59) == 0);
      core_rd_valid = ($urandom_range(0, 3) != 0);
      core_rs1 = 5'($urandom_range(0, 7)); core_rs2 = 5'($urandom_range(0, 7));
      core_wr_valid = ($urandom_range(0, 1) == 1);
      core_wr_addr = 5'($urandom_range(0, 7)); core_wr_data = $urandom;
      dbg_req_valid = ($urandom_range(0, 2) != 0);
      dbg_req_write = ($urandom_range(0, 1) == 1);
      dbg_req_addr = 5'($urandom_range(0, 7)); dbg_req_wdata = $urandom;
      cycle();
    end
    reset = 0; idle(); cycle(); cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
